prbs_xnor_checker: RTL and testbench
====================================

# prbs_xnor_checker

Serial receive-side checker for the team's XNOR-feedback PRBS pattern stream; it is the receiving end of the XNOR-LFSR pattern generator. It self-synchronises a local XNOR LFSR to the incoming bit stream, declares lock, and then counts bit errors against the free-running prediction. It sits at the end of a serial link or loopback path as the pass/fail monitor for link bring-up.

## Interface
- `WIDTH`, 7: LFSR length. Default is PRBS7, period 127.
- `TAP_A`, 7: first feedback tap, 1-based.
- `TAP_B`, 6: second feedback tap, 1-based.
- `LOCK_COUNT`, 16: consecutive matching bits required in VERIFY before declaring lock.
- `LOSS_COUNT`, 4: consecutive mismatches in LOCKED that drop lock.
- `ERR_W`, 16: width of the error counter.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_bit` is sampled this cycle; no state advances while low.
- `in_bit` input 1: received serial bit.
- `clear_count` input 1: synchronous clear of `err_count`.
- `locked` output 1: checker synchronised.
- `err_pulse` output 1: one-cycle pulse per mismatch detected in LOCKED.
- `err_count` output ERR_W: saturating count of errors detected in LOCKED.
- `sync_state` output 2: current FSM state, for debug. SEED=0, VERIFY=1, LOCKED=2.

## Operation
- Shift register `sr[WIDTH-1:0]`. `sr[0]` holds the newest bit.
- Prediction: `pred = ~(sr[TAP_A-1] ^ sr[TAP_B-1])`.
- All-ones is the XNOR lock-up state.

States (advance only on `in_valid`=1):
- SEED:
  - Shift `in_bit` into `sr` and increment `seed_cnt`.
  - Once `seed_cnt` reaches WIDTH and `sr` is not all-ones, go to VERIFY with `match_cnt`=0.
  - If `sr` is all-ones, stay in SEED and re-check on every subsequent bit.
- VERIFY:
  - Compare `in_bit` with `pred`, then shift `in_bit` into `sr`.
  - Match: increment `match_cnt`. On the LOCK_COUNT-th match, go to LOCKED.
  - Mismatch: go to SEED with `seed_cnt`=0. `err_count` is not touched.
- LOCKED:
  - Shift `pred` into `sr`, not `in_bit`, so the LFSR free-runs and errors do not propagate.
  - Mismatch: assert `err_pulse`, increment `err_count` (saturating at 2^ERR_W−1), and increment `miss_cnt`.
  - Match: clear `miss_cnt`.
  - When `miss_cnt` reaches LOSS_COUNT, go to SEED with `seed_cnt`=0.
- `err_count` survives loss of lock. Only `reset` or `clear_count` zero it.
- `clear_count` and an error in the same cycle: `err_count` becomes 1, so the error is not lost.
- `clear_count` while saturated: `err_count` becomes 0.

## Timing
- All outputs are registered.
- Reset values:
  - `locked`=0, `err_pulse`=0, `err_count`=0, `sync_state`=SEED.
  - `sr`=0, `seed_cnt`=0, `match_cnt`=0, `miss_cnt`=0.
- Reset takes priority over all other inputs in the same cycle.
- Reset asserted mid-operation returns every output to its reset value on the next edge.
- Lock latency from reset with a clean stream: WIDTH + LOCK_COUNT valid bits (23 at defaults). `locked` rises at the edge that samples the last of those bits.
- `err_pulse` and the `err_count` increment appear at the edge that samples the erroneous bit. `err_pulse` is high for exactly one cycle.
- `locked` falls at the edge that samples the LOSS_COUNT-th consecutive mismatch. That mismatch is still counted.
- Cycles with `in_valid`=0:
  - Hold all state.
  - `err_pulse` returns to 0.
  - `clear_count` still acts.

## Structure
- Shared package `prbs_pkg`:
  - state enum (SEED, VERIFY, LOCKED);
  - default WIDTH, TAP_A and TAP_B constants;
  - the all-ones lock-up constant.
- The generator uses the same package.
- One sub-module, `prbs_xnor_lfsr`: combinational next-bit predictor (taps in, `pred` out), shared with the generator.
- FSM, counters and compare logic live in the top module.

## Test plan
- **Clean lock:** reset, then 200 valid bits from the XNOR PRBS7 generator seeded 0.
  - `locked` rises after the 23rd bit.
  - `err_count`=0 at the end.
  - `sync_state` steps 0→1→2.
- **Single error:** after lock, invert bit 100.
  - One-cycle `err_pulse`, `err_count`=1, `locked` stays 1.
- **Lock-up guard:** feed 50 consecutive ones after reset.
  - `sync_state` stays 0 and `locked`=0 throughout.
- **Loss and relock:** after lock, invert 4 consecutive bits.
  - `err_count`=4 and `locked` falls on the 4th bit.
  - Continue the clean stream: `locked` returns after 23 further bits and `err_count` is still 4.
- **Saturation and clear (ERR_W=4):** 20 isolated errors spaced 10 bits apart.
  - `err_count` saturates at 15.
  - `clear_count` in the same cycle as a further error gives `err_count`=1.
- **Gaps and reset:** random `in_valid` gaps (30% low) give the same lock point in valid-bit terms. `reset` pulsed while LOCKED gives all outputs 0 on the next edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS pattern generator and checker.
// Provides the checker's synchronisation state encoding, the default PRBS7
// polynomial (x^7 + x^6 + 1), and the XNOR lock-up pattern for that length.
package prbs_pkg;

  // Encoding is visible on the checker's sync_state debug port.
  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_TAP_A = 7;
  localparam int DEF_TAP_B = 6;

  // An XNOR LFSR holding all ones feeds back a one forever.
  localparam logic [DEF_WIDTH-1:0] DEF_LOCKUP = '1;

endpackage

// File: rtl/prbs_xnor_lfsr.sv
// Combinational next-bit predictor for an XNOR-feedback LFSR.
// Shared by the PRBS generator and checker.
//   sr   : LFSR contents, sr[0] is the newest bit
//   pred : predicted next bit, ~(sr[TAP_A-1] ^ sr[TAP_B-1])
module prbs_xnor_lfsr
  import prbs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP_A = DEF_TAP_A,
  parameter int TAP_B = DEF_TAP_B
) (
  input  logic [WIDTH-1:0] sr,
  output logic             pred
);

  // Selecting the taps with a mask keeps the whole register in the reduction,
  // so untapped bits are not left dangling.
  localparam logic [WIDTH-1:0] TAP_MASK =
    (WIDTH'(1) << (TAP_A - 1)) | (WIDTH'(1) << (TAP_B - 1));

  always_comb begin
    pred = ~(^(sr & TAP_MASK));
  end

endmodule

// File: rtl/prbs_xnor_checker.sv
// Receive-side checker for the XNOR-feedback PRBS stream. Self-synchronises a
// local LFSR to the incoming bits (SEED -> VERIFY -> LOCKED), then free-runs
// and counts bit errors against its own prediction.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : in_bit is sampled this cycle; state holds while low
//   in_bit      : received serial bit
//   clear_count : synchronous clear of err_count
//   locked      : checker synchronised
//   err_pulse   : one-cycle pulse per mismatch while locked
//   err_count   : saturating count of errors seen while locked
//   sync_state  : FSM state for debug (SEED=0, VERIFY=1, LOCKED=2)
module prbs_xnor_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TAP_A      = DEF_TAP_A,
  parameter int TAP_B      = DEF_TAP_B,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       sync_state
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  localparam logic [SW-1:0]    SEED_FULL  = SW'(WIDTH);
  localparam logic [SW-1:0]    SEED_LAST  = SW'(WIDTH - 1);
  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0]    MISS_LAST  = LW'(LOSS_COUNT - 1);
  localparam logic [WIDTH-1:0] LOCKUP     = '1;
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  sync_state_t      state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, sr_in;
  logic [SW-1:0]    seed_cnt, seed_cnt_nx;
  logic [MW-1:0]    match_cnt, match_cnt_nx;
  logic [LW-1:0]    miss_cnt, miss_cnt_nx;
  logic             pred;
  logic             mismatch;
  logic             err_hit;

  prbs_xnor_lfsr #(
    .WIDTH(WIDTH),
    .TAP_A(TAP_A),
    .TAP_B(TAP_B)
  ) u_lfsr (
    .sr  (sr),
    .pred(pred)
  );

  always_comb begin
    state_nx     = state;
    sr_nx        = sr;
    seed_cnt_nx  = seed_cnt;
    match_cnt_nx = match_cnt;
    miss_cnt_nx  = miss_cnt;
    err_hit      = 1'b0;
    mismatch     = in_bit ^ pred;
    sr_in        = {sr[WIDTH-2:0], in_bit};

    if (in_valid) begin
      case (state)
        ST_SEED: begin
          sr_nx = sr_in;
          if (seed_cnt != SEED_FULL) begin
            seed_cnt_nx = seed_cnt + SW'(1);
          end
          // Once full, keep re-checking every bit until the lock-up pattern clears.
          if (seed_cnt >= SEED_LAST && sr_in != LOCKUP) begin
            state_nx     = ST_VERIFY;
            match_cnt_nx = '0;
          end
        end
        ST_VERIFY: begin
          sr_nx = sr_in;
          if (!mismatch) begin
            match_cnt_nx = match_cnt + MW'(1);
            if (match_cnt == MATCH_LAST) begin
              state_nx    = ST_LOCKED;
              miss_cnt_nx = '0;
            end
          end else begin
            state_nx    = ST_SEED;
            seed_cnt_nx = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on our own prediction so a bad bit cannot corrupt the LFSR.
          sr_nx = {sr[WIDTH-2:0], pred};
          if (mismatch) begin
            err_hit     = 1'b1;
            miss_cnt_nx = miss_cnt + LW'(1);
            if (miss_cnt == MISS_LAST) begin
              state_nx    = ST_SEED;
              seed_cnt_nx = '0;
              miss_cnt_nx = '0;
            end
          end else begin
            miss_cnt_nx = '0;
          end
        end
        default: begin
          state_nx    = ST_SEED;
          seed_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      seed_cnt  <= seed_cnt_nx;
      match_cnt <= match_cnt_nx;
      miss_cnt  <= miss_cnt_nx;
      locked    <= (state_nx == ST_LOCKED);
      err_pulse <= err_hit;
      // A clear coinciding with an error keeps that error.
      if (clear_count) begin
        err_count <= err_hit ? ERR_W'(1) : '0;
      end else if (err_hit && err_count != ERR_MAX) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign sync_state = state;

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Self-checking bench for prbs_xnor_checker. Two instances (ERR_W=16 and
// ERR_W=4) see the same stimulus; a queue-based behavioural model predicts
// every output each cycle, and directed scenarios pin key points to literals.
module tb_prbs_xnor_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, in_valid = 1'b0, in_bit = 1'b0, clear_count = 1'b0;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  sync_state, sync_state4;

  prbs_xnor_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_count(clear_count), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .sync_state(sync_state)
  );

  prbs_xnor_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_count(clear_count), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .sync_state(sync_state4)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0/1/2 = seeding / verifying / locked.
  int m_mode, m_seed, m_match, m_miss, m_err16, m_err4;
  bit m_pulse, m_locked;
  bit m_seq[$];   // last 7 bits of the model's sequence, oldest first

  function automatic void model_step(bit v, bit b, bit clr, bit rst);
    bit p, err, ones;
    if (rst) begin
      m_mode = 0; m_seed = 0; m_match = 0; m_miss = 0;
      m_err16 = 0; m_err4 = 0; m_pulse = 0; m_locked = 0;
      m_seq.delete();
      repeat (7) m_seq.push_back(1'b0);
      return;
    end
    err = 1'b0;
    if (v) begin
      p = ~(m_seq[0] ^ m_seq[1]);   // 7 and 6 bits back
      case (m_mode)
        0: begin
          m_seq.push_back(b); void'(m_seq.pop_front());
          m_seed++;
          ones = 1'b1;
          foreach (m_seq[i]) if (!m_seq[i]) ones = 1'b0;
          if (m_seed >= 7 && !ones) begin m_mode = 1; m_match = 0; end
        end
        1: begin
          m_seq.push_back(b); void'(m_seq.pop_front());
          if (b == p) begin
            m_match++;
            if (m_match == 16) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_mode = 0; m_seed = 0;
          end
        end
        default: begin
          m_seq.push_back(p); void'(m_seq.pop_front());
          if (b != p) begin
            err = 1'b1;
            m_miss++;
            if (m_miss == 4) begin m_mode = 0; m_seed = 0; m_miss = 0; end
          end else begin
            m_miss = 0;
          end
        end
      endcase
    end
    if (clr) m_err16 = int'(err);
    else if (err && m_err16 < 65535) m_err16++;
    if (clr) m_err4 = int'(err);
    else if (err && m_err4 < 15) m_err4++;
    m_pulse = err;
    m_locked = (m_mode == 2);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", int'(locked), int'(m_locked));
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_count", int'(err_count), m_err16);
      chk("sync_state", int'(sync_state), m_mode);
      chk("locked_w4", int'(locked4), int'(m_locked));
      chk("err_pulse_w4", int'(err_pulse4), int'(m_pulse));
      chk("err_count_w4", int'(err_count4), m_err4);
      chk("sync_state_w4", int'(sync_state4), m_mode);
    end
  end

  // Reference XNOR PRBS7 generator.
  logic [6:0] g = '0;
  int vcnt = 0;

  function automatic bit gen_next();
    bit nb;
    nb = ~(g[6] ^ g[5]);
    g = {g[5:0], nb};
    return nb;
  endfunction

  task automatic drive(input bit v, input bit b, input bit clr, input bit rst);
    in_valid = v; in_bit = b; clear_count = clr; reset = rst;
    @(posedge clk);
    model_step(v, b, clr, rst);
    #1;
  endtask

  task automatic send(input bit inv, input bit clr);
    bit b;
    b = gen_next() ^ inv;
    drive(1'b1, b, clr, 1'b0);
    vcnt++;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    g = '0;
    vcnt = 0;
  endtask

  initial begin
    int lock_at, st1_at, drops, pulses, bad, relock;

    // Clean lock with a single error at bit 100
    do_reset();
    cmp_en = 1'b1;
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_state", int'(sync_state), 0);
    lock_at = -1; st1_at = -1; drops = 0; pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      send(i == 100, 1'b0);
      if (st1_at < 0 && sync_state == 2'd1) st1_at = i;
      if (lock_at < 0 && locked) lock_at = i;
      if (lock_at > 0 && !locked) drops++;
      if (err_pulse) pulses++;
      if (i == 99) chk("clean_err_count", int'(err_count), 0);
    end
    chk("lock_point", lock_at, 23);
    chk("verify_entry", st1_at, 7);
    chk("single_err_count", int'(err_count), 1);
    chk("single_err_pulses", pulses, 1);
    chk("single_err_no_drop", drops, 0);

    // Lock-up guard: all ones never leaves SEED
    do_reset();
    bad = 0;
    repeat (50) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (sync_state != 2'd0 || locked) bad++;
    end
    chk("lockup_guard", bad, 0);

    // Loss of lock and relock
    do_reset();
    relock = -1;
    for (int i = 1; i <= 100; i++) begin
      send(i >= 41 && i <= 44, 1'b0);
      if (i == 43) chk("loss_hold_3", int'(locked), 1);
      if (i == 44) begin
        chk("loss_drop_4", int'(locked), 0);
        chk("loss_err_count", int'(err_count), 4);
      end
      if (i > 44 && relock < 0 && locked) relock = i - 44;
    end
    chk("relock_after", relock, 23);
    chk("relock_err_count", int'(err_count), 4);

    // Saturation and clear
    do_reset();
    repeat (30) send(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      repeat (9) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    chk("sat_w4", int'(err_count4), 15);
    chk("count_w16", int'(err_count), 20);
    chk("locked_through_errs", int'(locked), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_saturated_w4", int'(err_count4), 0);
    repeat (9) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("err_after_clear_w4", int'(err_count4), 1);
    repeat (9) send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    chk("clear_with_err_w4", int'(err_count4), 1);
    chk("clear_with_err_w16", int'(err_count), 1);

    // Random gaps, then reset while locked
    do_reset();
    lock_at = -1;
    for (int i = 0; i < 400 && lock_at < 0; i++) begin
      if ($urandom_range(0, 99) < 30) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else send(1'b0, 1'b0);
      if (locked) lock_at = vcnt;
    end
    chk("gap_lock_point", lock_at, 23);
    repeat (5) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    repeat (3) send(1'b0, 1'b0);
    chk("pre_reset_err", int'(err_count), 1);
    chk("pre_reset_locked", int'(locked), 1);
    drive(1'b1, ~gen_next(), 1'b0, 1'b1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_state", int'(sync_state), 0);

    // Randomised soak: gaps, bit errors, clears, occasional reset
    for (int i = 0; i < 3000; i++) begin
      bit v, inv, clr, rst;
      v   = ($urandom_range(0, 99) >= 30);
      inv = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 999) < 2);
      if (v) drive(1'b1, gen_next() ^ inv, clr, rst);
      else drive(1'b0, 1'($urandom_range(0, 1)), clr, rst);
    end

    cmp_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
